aes_mix_column: RTL and testbench

- Combinational AES MixColumns / InvMixColumns on one 32-bit state column, GF(2^8) with polynomial x^8+x^4+x^3+x+1 (0x11B).
- Sits in the AES round datapath next to the SubBytes/ShiftRows stages.
- The encrypt and decrypt paths use the same block; a direction input selects between them.

---
 rtl/aes_pkg.sv | 53 +++++
 rtl/aes_mix_byte.sv | 26 ++
 rtl/aes_mix_column.sv | 40 ++++
 tb/tb_aes_mix_column.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES types and GF(2^8) constant-multiply helpers (poly 0x11B).
package aes_pkg;

  typedef logic [7:0]  aes_byte_t;
  typedef logic [31:0] aes_col_t;

  localparam aes_byte_t AES_POLY_RED = 8'h1B;

  function automatic aes_byte_t gf_xtime(input aes_byte_t a);
    return {a[6:0], 1'b0} ^ (a[7] ? AES_POLY_RED : '0);
  endfunction

  function automatic aes_byte_t gf_mul2(input aes_byte_t a);
    return gf_xtime(a);
  endfunction

  function automatic aes_byte_t gf_mul3(input aes_byte_t a);
    return gf_xtime(a) ^ a;
  endfunction

  function automatic aes_byte_t gf_mul9(input aes_byte_t a);
    aes_byte_t x1, x2, x3;
    x1 = gf_xtime(a);
    x2 = gf_xtime(x1);
    x3 = gf_xtime(x2);
    return x3 ^ a;
  endfunction

  function automatic aes_byte_t gf_mulb(input aes_byte_t a);
    aes_byte_t x1, x2, x3;
    x1 = gf_xtime(a);
    x2 = gf_xtime(x1);
    x3 = gf_xtime(x2);
    return x3 ^ x1 ^ a;
  endfunction

  function automatic aes_byte_t gf_muld(input aes_byte_t a);
    aes_byte_t x1, x2, x3;
    x1 = gf_xtime(a);
    x2 = gf_xtime(x1);
    x3 = gf_xtime(x2);
    return x3 ^ x2 ^ a;
  endfunction

  function automatic aes_byte_t gf_mule(input aes_byte_t a);
    aes_byte_t x1, x2, x3;
    x1 = gf_xtime(a);
    x2 = gf_xtime(x1);
    x3 = gf_xtime(x2);
    return x3 ^ x2 ^ x1;
  endfunction

endpackage

// File: rtl/aes_mix_byte.sv
// One MixColumns/InvMixColumns output byte from a rotated column.
// col_i[31:24] is the byte on the diagonal for this output row.
module aes_mix_byte
  import aes_pkg::*;
(
  input  logic        fwd_ninv_i,
  input  logic [31:0] col_i,
  output logic [7:0]  byte_o
);

  aes_byte_t a0, a1, a2, a3;

  // Row product: {2,3,1,1} forward, {e,b,d,9} inverse.
  always_comb begin
    a0 = col_i[31:24];
    a1 = col_i[23:16];
    a2 = col_i[15:8];
    a3 = col_i[7:0];
    if (fwd_ninv_i) begin
      byte_o = gf_mul2(a0) ^ gf_mul3(a1) ^ a2 ^ a3;
    end else begin
      byte_o = gf_mule(a0) ^ gf_mulb(a1) ^ gf_muld(a2) ^ gf_mul9(a3);
    end
  end

endmodule

// File: rtl/aes_mix_column.sv
// Combinational AES MixColumns / InvMixColumns on one 32-bit column.
// clk_i and rst_i are present only for interface uniformity.
module aes_mix_column
  import aes_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        fwd_ninv_i,
  input  logic [31:0] col_i,
  output logic [31:0] col_o
);

  aes_col_t  rot_w [4];
  aes_byte_t byte_w [4];
  logic      unused_inputs;

  assign unused_inputs = clk_i ^ rst_i;

  // Output row i sees the column rotated left by i bytes.
  always_comb begin
    for (int unsigned i = 0; i < 4; i++) begin
      rot_w[i] = '0;
    end
    rot_w[0] = col_i;
    rot_w[1] = {col_i[23:0], col_i[31:24]};
    rot_w[2] = {col_i[15:0], col_i[31:16]};
    rot_w[3] = {col_i[7:0],  col_i[31:8]};
  end

  for (genvar g = 0; g < 4; g++) begin : g_row
    aes_mix_byte u_mix_byte (
      .fwd_ninv_i (fwd_ninv_i),
      .col_i      (rot_w[g]),
      .byte_o     (byte_w[g])
    );
  end

  assign col_o = {byte_w[0], byte_w[1], byte_w[2], byte_w[3]};

endmodule

// File: tb/tb_aes_mix_column.sv
// Self-checking bench for aes_mix_column with a scoreboard queue.
module tb_aes_mix_column;
  import aes_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        clk_run;
  logic        fwd_ninv;
  logic [31:0] col_i;
  logic [31:0] col_o;
  logic [31:0] inv_o;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_entry_t;

  sb_entry_t sb_q [$];

  aes_mix_column u_dut (
    .clk_i      (clk),
    .rst_i      (rst_n),
    .fwd_ninv_i (fwd_ninv),
    .col_i      (col_i),
    .col_o      (col_o)
  );

  // Inverse stage chained after the main instance for round-trip checks.
  aes_mix_column u_inv (
    .clk_i      (clk),
    .rst_i      (rst_n),
    .fwd_ninv_i (1'b0),
    .col_i      (col_o),
    .col_o      (inv_o)
  );

  initial clk = 1'b0;
  always #5 if (clk_run) clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Reference: generic shift-and-add GF(2^8) multiply.
  function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    logic       hi;
    p  = '0;
    aa = a;
    bb = b;
    for (int k = 0; k < 8; k++) begin
      if (bb[0]) p = p ^ aa;
      hi = aa[7];
      aa = {aa[6:0], 1'b0};
      if (hi) aa = aa ^ 8'h1B;
      bb = {1'b0, bb[7:1]};
    end
    return p;
  endfunction

  function automatic logic [31:0] ref_col(input logic [31:0] c, input logic fwd);
    logic [7:0] a [4];
    logic [7:0] coef [4];
    logic [7:0] b;
    logic [31:0] r;
    a[0] = c[31:24]; a[1] = c[23:16]; a[2] = c[15:8]; a[3] = c[7:0];
    if (fwd) begin
      coef[0] = 8'h02; coef[1] = 8'h03; coef[2] = 8'h01; coef[3] = 8'h01;
    end else begin
      coef[0] = 8'h0E; coef[1] = 8'h0B; coef[2] = 8'h0D; coef[3] = 8'h09;
    end
    r = '0;
    for (int row = 0; row < 4; row++) begin
      b = '0;
      for (int j = 0; j < 4; j++) begin
        b = b ^ ref_mul(coef[(j - row + 4) % 4], a[j]);
      end
      r = {r[23:0], b};
    end
    return r;
  endfunction

  task automatic score(input string tag);
    sb_entry_t e;
    #1;
    if (sb_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'h1, 32'h0);
    end else begin
      e = sb_q.pop_front();
      check(e.tag, col_o, e.exp);
    end
  endtask

  task automatic apply_exp(input string tag, input logic [31:0] c, input logic fwd,
                           input logic [31:0] exp);
    col_i    = c;
    fwd_ninv = fwd;
    sb_q.push_back('{tag, exp});
    score(tag);
  endtask

  task automatic apply_model(input string tag, input logic [31:0] c, input logic fwd);
    apply_exp(tag, c, fwd, ref_col(c, fwd));
  endtask

  task automatic run_vectors(input string pfx);
    apply_exp({pfx, "zero_fwd"}, 32'h00000000, 1'b1, 32'h00000000);
    apply_exp({pfx, "zero_inv"}, 32'h00000000, 1'b0, 32'h00000000);
    apply_exp({pfx, "v1_fwd"},   32'hdb135345, 1'b1, 32'h8e4da1bc);
    apply_exp({pfx, "v1_inv"},   32'h8e4da1bc, 1'b0, 32'hdb135345);
    apply_exp({pfx, "v2_fwd"},   32'hf20a225c, 1'b1, 32'h9fdc589d);
    apply_exp({pfx, "v2_inv"},   32'h9fdc589d, 1'b0, 32'hf20a225c);
    apply_exp({pfx, "fp01_fwd"}, 32'h01010101, 1'b1, 32'h01010101);
    apply_exp({pfx, "fp01_inv"}, 32'h01010101, 1'b0, 32'h01010101);
    apply_exp({pfx, "fpc6_fwd"}, 32'hc6c6c6c6, 1'b1, 32'hc6c6c6c6);
    apply_exp({pfx, "fpc6_inv"}, 32'hc6c6c6c6, 1'b0, 32'hc6c6c6c6);
    // Direction toggle with a fixed column switches immediately.
    apply_exp({pfx, "tog_fwd"},  32'hdb135345, 1'b1, 32'h8e4da1bc);
    apply_exp({pfx, "tog_inv"},  32'hdb135345, 1'b0, ref_col(32'hdb135345, 1'b0));
  endtask

  initial begin
    logic [7:0]  a;
    logic [31:0] r;

    clk_run  = 1'b0;
    rst_n    = 1'b0;
    fwd_ninv = 1'b1;
    col_i    = '0;

    // Reset state: asserted reset, idle clock, zero column.
    #1;
    check("reset_zero", col_o, 32'h0);

    // Exhaustive GF helper checks.
    for (int v = 0; v < 256; v++) begin
      a = v[7:0];
      check("mul2", {24'h0, gf_mul2(a)}, {24'h0, ref_mul(8'h02, a)});
      check("mul3", {24'h0, gf_mul3(a)}, {24'h0, ref_mul(8'h03, a)});
      check("mul9", {24'h0, gf_mul9(a)}, {24'h0, ref_mul(8'h09, a)});
      check("mulb", {24'h0, gf_mulb(a)}, {24'h0, ref_mul(8'h0B, a)});
      check("muld", {24'h0, gf_muld(a)}, {24'h0, ref_mul(8'h0D, a)});
      check("mule", {24'h0, gf_mule(a)}, {24'h0, ref_mul(8'h0E, a)});
    end
    a = 8'h80;
    check("spot_mul2", {24'h0, gf_mul2(a)}, 32'h1B);
    check("spot_mul3", {24'h0, gf_mul3(a)}, 32'h9B);
    check("spot_mul9", {24'h0, gf_mul9(a)}, 32'hEC);
    check("spot_mulb", {24'h0, gf_mulb(a)}, 32'hF7);
    check("spot_muld", {24'h0, gf_muld(a)}, 32'hDA);
    check("spot_mule", {24'h0, gf_mule(a)}, 32'h41);

    // Known vectors and fixed points, clk=0 and rst asserted.
    run_vectors("hold_");

    // Random columns against the reference model, both directions.
    for (int n = 0; n < 200; n++) begin
      r = $urandom;
      apply_model("rand_fwd", r, 1'b1);
      r = $urandom;
      apply_model("rand_inv", r, 1'b0);
    end

    // Round trip through the chained inverse instance.
    fwd_ninv = 1'b1;
    for (int n = 0; n < 10000; n++) begin
      r     = $urandom;
      col_i = r;
      #1;
      check("round_trip", inv_o, r);
    end

    // Clock toggling and reset pulses must not disturb a fixed column.
    col_i    = 32'hdb135345;
    fwd_ninv = 1'b1;
    clk_run  = 1'b1;
    for (int cyc = 0; cyc < 8; cyc++) begin
      @(posedge clk);
      if (cyc == 2) rst_n = 1'b1;
      if (cyc == 4) rst_n = 1'b0;
      if (cyc == 5) rst_n = 1'b1;
      #1;
      check("clk_pos_hold", col_o, 32'h8e4da1bc);
      @(negedge clk);
      #1;
      check("clk_neg_hold", col_o, 32'h8e4da1bc);
    end

    // Vectors again with reset released and the clock running.
    run_vectors("run_");

    clk_run = 1'b0;
    if (sb_q.size() != 0) begin
      check("sb_leftover", sb_q.size(), 32'h0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
